imm_gen: RTL and testbench



---
 rtl/imm_gen.sv | 78 +++++++
 tb/tb_imm_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Immediate generator for the RV32I decode stage. The decoder supplies an
//   immediate-format code, and this block picks the matching bit fields out of
//   the instruction word. It sign- or zero-extends the result to 32 bits and
//   registers it. Output latency is one cycle, so the value lines up with the
//   next pipeline stage.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset; clears both outputs
//   inst     in  32  raw instruction word
//   imm_sel  in   5  format select: 0=R 1=S 2=B 3=U 4=J 5=I 6=I*(shamt),
//                    7..31 reserved
//   imm      out 32  registered, extended immediate
//   imm_err  out  1  registered flag, set when the sampled imm_sel was reserved
//
// There is no handshake: both registers capture on every rising edge, with no
// enable and no stall. Nothing in the block depends on earlier inputs.
// ---------------------------------------------------------------------------
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [4:0]  imm_sel,
  output logic [31:0] imm,
  output logic        imm_err
);

  localparam logic [4:0] SEL_R  = 5'd0;
  localparam logic [4:0] SEL_S  = 5'd1;
  localparam logic [4:0] SEL_B  = 5'd2;
  localparam logic [4:0] SEL_U  = 5'd3;
  localparam logic [4:0] SEL_J  = 5'd4;
  localparam logic [4:0] SEL_I  = 5'd5;
  localparam logic [4:0] SEL_IS = 5'd6;

  logic [31:0] imm_d, imm_q;
  logic        err_d, err_q;

  // Next-state mux. Each arm reads only the bits that its format defines, so
  // every other instruction bit is a don't-care for that select.
  always_comb begin
    imm_d = 32'h0000_0000;
    err_d = 1'b0;
    case (imm_sel)
      SEL_R:  imm_d = 32'h0000_0000;
      SEL_S:  imm_d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SEL_B:  imm_d = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
      SEL_U:  imm_d = {inst[31:12], 12'h000};
      SEL_J:  imm_d = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
      SEL_I:  imm_d = {{20{inst[31]}}, inst[31:20]};
      // Shift amount is zero-extended. funct7 (for example SRAI's bit 30)
      // is deliberately left out.
      SEL_IS: imm_d = {27'b0, inst[24:20]};
      default: begin
        imm_d = 32'h0000_0000;
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= 32'h0000_0000;
      err_q <= 1'b0;
    end else begin
      imm_q <= imm_d;
      err_q <= err_d;
    end
  end

  assign imm     = imm_q;
  assign imm_err = err_q;

endmodule

// File: tb/tb_imm_gen.sv
// ---------------------------------------------------------------------------
// tb_imm_gen
//   Directed testbench for imm_gen. Every vector carries an expected result
//   that was worked out by hand. The expected result goes into a queue when
//   the vector is driven and is popped one edge later. Between edges the
//   bench also checks that the outputs still hold the previous result.
// ---------------------------------------------------------------------------
module tb_imm_gen;

  localparam int W = 33;  // {imm_err, imm}

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [4:0]  imm_sel;
  logic [31:0] imm;
  logic        imm_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           total;
  int           bad;

  imm_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inst    (inst),
    .imm_sel (imm_sel),
    .imm     (imm),
    .imm_err (imm_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got err=%0b imm=%08h, required err=%0b imm=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Call this away from a clock edge. It drives the vector, confirms that the
  // outputs still show the previous result, and then confirms that the new
  // result shows up exactly one edge later.
  task automatic apply(input string tag, input logic [31:0] i,
                       input logic [4:0] s, input logic [31:0] e_imm,
                       input logic e_err);
    inst    = i;
    imm_sel = s;
    exp_q.push_back({e_err, e_imm});
    #1;
    check({tag, "_hold"}, {imm_err, imm}, last_exp);
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check(tag, {imm_err, imm}, last_exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total    = 0;
    bad      = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    inst     = 32'hFFFF_FFFF;
    imm_sel  = 5'd5;

    // Reset must hold both outputs at 0 across several edges.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {imm_err, imm}, 33'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    apply("reset_release", 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1'b0);

    // I and I*
    apply("i_neg50",   32'b111111001110_00000_000_00001_0010011, 5'd5, 32'hFFFF_FFCE, 1'b0);
    apply("ishamt_4",  32'b0000000_00100_00010_001_00001_0010011, 5'd6, 32'd4, 1'b0);
    apply("srai_4",    32'h4040_D093, 5'd6, 32'd4, 1'b0);
    apply("ishamt_31", 32'hFFFF_FFFF, 5'd6, 32'd31, 1'b0);

    // S and B
    apply("s_52",      32'b0000001_00001_00010_010_10100_0100011, 5'd1, 32'd52, 1'b0);
    apply("s_neg4",    32'hFE11_2E23, 5'd1, 32'hFFFF_FFFC, 1'b0);
    apply("b_8",       32'b0000000_00010_00001_000_01000_1100011, 5'd2, 32'd8, 1'b0);
    apply("b_neg4",    32'hFE20_8EE3, 5'd2, 32'hFFFF_FFFC, 1'b0);

    // U and J
    apply("u_12345",   32'h1234_50B7, 5'd3, 32'h1234_5000, 1'b0);
    apply("j_16",      32'h0100_00EF, 5'd4, 32'd16, 1'b0);
    apply("j_2",       32'h0020_00EF, 5'd4, 32'd2, 1'b0);
    apply("j_neg4",    32'hFFDF_F0EF, 5'd4, 32'hFFFF_FFFC, 1'b0);

    // R and reserved selects
    apply("r_zero",    32'h0021_80B3, 5'd0, 32'h0, 1'b0);
    apply("rsv_7",     32'hFFFF_FFFF, 5'd7, 32'h0, 1'b1);
    apply("rsv_31",    32'hFFFF_FFFF, 5'd31, 32'h0, 1'b1);
    apply("rsv_16",    32'hFFFF_FFFF, 5'd16, 32'h0, 1'b1);
    apply("err_clear", 32'h0021_80B3, 5'd0, 32'h0, 1'b0);

    // Back-to-back I, S, B, U, J, one new vector every cycle
    apply("b2b_i",     32'b111111001110_00000_000_00001_0010011, 5'd5, 32'hFFFF_FFCE, 1'b0);
    apply("b2b_s",     32'hFE11_2E23, 5'd1, 32'hFFFF_FFFC, 1'b0);
    apply("b2b_b",     32'b0000000_00010_00001_000_01000_1100011, 5'd2, 32'd8, 1'b0);
    apply("b2b_u",     32'h1234_50B7, 5'd3, 32'h1234_5000, 1'b0);
    apply("b2b_j",     32'h0100_00EF, 5'd4, 32'd16, 1'b0);

    // Glitch: drive an unrelated vector mid-cycle and check that the outputs
    // hold. Then settle on the real vector before the edge.
    inst    = 32'hFFFF_FFFF;
    imm_sel = 5'd5;
    #2;
    check("glitch_hold_a", {imm_err, imm}, last_exp);
    imm_sel = 5'd9;
    #2;
    check("glitch_hold_b", {imm_err, imm}, last_exp);
    apply("glitch_u",  32'h1234_50B7, 5'd3, 32'h1234_5000, 1'b0);

    // Assert reset mid-cycle: the outputs must clear at once, not at the
    // next edge.
    apply("pre_rst_i", 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_now", {imm_err, imm}, 33'h0);
    @(posedge clk);
    #1;
    check("midrst_edge", {imm_err, imm}, 33'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = '0;
    apply("post_rst_j", 32'hFFDF_F0EF, 5'd4, 32'hFFFF_FFFC, 1'b0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
